// File: rtl/patch_led_sequencer_if.sv
// Bus between the color detector / CSL decoder side and the LED sequencer.
// The master side drives the detector inputs, the slave side (the sequencer)
// drives the LED and status outputs. There is no valid/ready handshake here:
// every input is sampled on each clock edge. Every output is registered or
// decoded from registers, so it changes only after a clock edge.
interface patch_led_sequencer_if #(
    parameter int NUM_LEDS = 3
);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [1:0]            color;
    logic                  done;
    logic                  mi_led;
    logic                  clear;
    logic                  patch_enable;
    logic [3*NUM_LEDS-1:0] rgb_leds;
    logic [2:0]            rgb_mi;
    logic [IDX_W-1:0]      led_idx;
    logic                  full;
    logic                  blinking;

    modport master (
        output color, done, mi_led, clear,
        input  patch_enable, rgb_leds, rgb_mi, led_idx, full, blinking
    );

    modport slave (
        input  color, done, mi_led, clear,
        output patch_enable, rgb_leds, rgb_mi, led_idx, full, blinking
    );
endinterface

// File: rtl/patch_led_sequencer.sv
// Patch LED sequencer: latches each stable detected color into the next of
// NUM_LEDS RGB slots, wraps when all slots are full, blinks every slot while
// done is high, and runs a retriggerable yellow MI indicator timer.
module patch_led_sequencer #(
    parameter int         NUM_LEDS    = 3,
    parameter int         STABLE_CYC  = 4,
    parameter int         BLINK_CYC   = 1000000,
    parameter int         MI_CYC      = 2000000,
    parameter logic [2:0] BLINK_COLOR = 3'b010
) (
    input logic                   clk_1MHz,
    input logic                   rst_n,
    patch_led_sequencer_if.slave  bus
);
    localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int STAB_W  = $clog2(STABLE_CYC + 1);
    localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int MI_W    = $clog2(MI_CYC + 1);
    localparam int SLOT_W  = 3 * NUM_LEDS;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_LEDS - 1);
    localparam logic [STAB_W-1:0]  STAB_TGT   = STAB_W'(STABLE_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
    localparam logic [MI_W-1:0]    MI_LOAD    = MI_W'(MI_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BLINK = 2'd2
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slots;
    logic [SLOT_W-1:0]   slots_written;
    logic [IDX_W-1:0]    led_idx_q;
    logic                full_q;
    logic                patch_enable_q;
    logic                blinking_q;
    logic                phase;
    logic [BLINK_W-1:0]  blink_cnt;

    logic [1:0]          prev_color;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_next;
    logic                latch_evt;

    logic                mi_prev;
    logic [MI_W-1:0]     mi_cnt;

    logic [2:0]          color_rgb;

    // Map the detector code to the one-hot RGB bit pattern of a slot.
    always_comb begin
        color_rgb = 3'b000;
        case (bus.color)
            2'd1:    color_rgb = 3'b001;
            2'd2:    color_rgb = 3'b010;
            2'd3:    color_rgb = 3'b100;
            default: color_rgb = 3'b000;
        endcase
    end

    // Stability filter: count consecutive identical nonzero samples (including
    // the current one) and flag the edge on which the count reaches the target.
    // The count saturates so a color held indefinitely produces one event.
    always_comb begin
        stab_next = '0;
        latch_evt = 1'b0;
        if (bus.color != 2'd0) begin
            if (bus.color != prev_color) begin
                stab_next = STAB_W'(1);
                latch_evt = (STABLE_CYC == 1);
            end else if (stab_cnt != STAB_TGT) begin
                stab_next = stab_cnt + 1'b1;
                latch_evt = (stab_next == STAB_TGT);
            end else begin
                stab_next = stab_cnt;
            end
        end
    end

    // Filter history registers.
    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            prev_color <= 2'd0;
            stab_cnt   <= '0;
        end else begin
            prev_color <= bus.color;
            stab_cnt   <= stab_next;
        end
    end

    // Slot image after a latch: a full bank is emptied first so a wrap starts
    // a fresh row, then the mapped color goes into the current slot.
    always_comb begin
        slots_written = full_q ? '0 : slots;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (led_idx_q == IDX_W'(k)) begin
                slots_written[3*k +: 3] = color_rgb;
            end
        end
    end

    // Main sequencer FSM. done has top priority (outside BLINK), then clear,
    // then a latch event; a latch arriving with done is dropped.
    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            state          <= IDLE;
            slots          <= '0;
            led_idx_q      <= '0;
            full_q         <= 1'b0;
            patch_enable_q <= 1'b0;
            blinking_q     <= 1'b0;
            phase          <= 1'b0;
            blink_cnt      <= '0;
        end else if (state != BLINK && bus.done) begin
            state          <= BLINK;
            phase          <= 1'b0;
            blink_cnt      <= '0;
            patch_enable_q <= 1'b0;
            blinking_q     <= 1'b1;
        end else begin
            case (state)
                BLINK: begin
                    if (!bus.done) begin
                        state      <= IDLE;
                        slots      <= '0;
                        led_idx_q  <= '0;
                        full_q     <= 1'b0;
                        blinking_q <= 1'b0;
                        phase      <= 1'b0;
                        blink_cnt  <= '0;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clear) begin
                        slots          <= '0;
                        led_idx_q      <= '0;
                        full_q         <= 1'b0;
                        patch_enable_q <= 1'b0;
                    end else if (latch_evt) begin
                        slots          <= slots_written;
                        patch_enable_q <= 1'b1;
                        state          <= HOLD;
                        full_q         <= (led_idx_q == LAST_IDX);
                        led_idx_q      <= (led_idx_q == LAST_IDX) ? '0 : led_idx_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.clear) begin
                        slots          <= '0;
                        led_idx_q      <= '0;
                        full_q         <= 1'b0;
                        patch_enable_q <= 1'b0;
                        state          <= IDLE;
                    end else if (bus.color == 2'd0) begin
                        patch_enable_q <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MI timer: a rising edge on mi_led (re)loads the count, otherwise it
    // decays to zero. Runs independently of the sequencer state.
    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            mi_prev <= 1'b0;
            mi_cnt  <= '0;
        end else begin
            mi_prev <= bus.mi_led;
            if (bus.mi_led && !mi_prev) begin
                mi_cnt <= MI_LOAD;
            end else if (mi_cnt != '0) begin
                mi_cnt <= mi_cnt - 1'b1;
            end
        end
    end

    assign bus.patch_enable = patch_enable_q;
    assign bus.led_idx      = led_idx_q;
    assign bus.full         = full_q;
    assign bus.blinking     = blinking_q;
    assign bus.rgb_mi       = (mi_cnt != '0) ? 3'b011 : 3'b000;
    assign bus.rgb_leds     = blinking_q ? (phase ? {NUM_LEDS{BLINK_COLOR}} : '0) : slots;

endmodule

// File: tb/tb_patch_led_sequencer.sv
// Directed bench for patch_led_sequencer: latch/wrap, stability filter, clear
// priority, blink timing, MI retrigger and reset mid-operation.
`timescale 1ns/1ps
module tb_patch_led_sequencer;
    localparam int         NUM_LEDS    = 3;
    localparam int         STABLE_CYC  = 4;
    localparam int         BLINK_CYC   = 5;
    localparam int         MI_CYC      = 10;
    localparam logic [2:0] BLINK_COLOR = 3'b010;
    localparam int         SW          = 17;

    logic clk;
    logic rst_n;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [SW-1:0] exp_q[$];
    string         tag_q[$];

    patch_led_sequencer_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    patch_led_sequencer #(
        .NUM_LEDS   (NUM_LEDS),
        .STABLE_CYC (STABLE_CYC),
        .BLINK_CYC  (BLINK_CYC),
        .MI_CYC     (MI_CYC),
        .BLINK_COLOR(BLINK_COLOR)
    ) dut (
        .clk_1MHz(clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected snapshot: {patch_enable, rgb_leds, rgb_mi, led_idx, full, blinking}
    function automatic logic [SW-1:0] snap(input logic pe, input logic [8:0] leds,
                                           input logic mi, input logic [1:0] idx,
                                           input logic fl, input logic bl);
        return {pe, leds, (mi ? 3'b011 : 3'b000), idx, fl, bl};
    endfunction

    function automatic logic [SW-1:0] observed();
        return {bus.patch_enable, bus.rgb_leds, bus.rgb_mi, bus.led_idx, bus.full, bus.blinking};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_exp(input string tag, input logic [SW-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Scoreboard compare: pop the oldest expectation and check the outputs.
    task automatic check_out();
        logic [SW-1:0] e;
        logic [SW-1:0] o;
        string         t;
        check_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $error("FAIL scoreboard_empty: observed %0d entries expected >0", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            assert (o === e) else begin
                err_cnt++;
                $error("FAIL %s: observed %h expected %h", t, o, e);
            end
        end
    endtask

    // Drive already set up; expectation for the state after the next edge.
    task automatic step(input string tag, input logic [SW-1:0] e);
        push_exp(tag, e);
        tick();
        check_out();
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.color  = 2'd0;
        bus.done   = 1'b0;
        bus.mi_led = 1'b0;
        bus.clear  = 1'b0;
        tick();
        step("reset", snap(0, 9'h000, 0, 2'd0, 0, 0));
        rst_n = 1'b1;

        // Sequential latch and wrap
        bus.color = 2'd1;
        tick_n(2);
        step("latch_not_yet", snap(0, 9'b000_000_000, 0, 2'd0, 0, 0));
        step("latch1", snap(1, 9'b000_000_001, 0, 2'd1, 0, 0));
        tick_n(2);
        bus.color = 2'd0;
        step("hold_release", snap(0, 9'b000_000_001, 0, 2'd1, 0, 0));
        tick();
        bus.color = 2'd2;
        tick_n(5);
        step("latch2", snap(1, 9'b000_010_001, 0, 2'd2, 0, 0));
        bus.color = 2'd0;
        tick_n(2);
        bus.color = 2'd3;
        tick_n(5);
        step("latch3_full", snap(1, 9'b100_010_001, 0, 2'd0, 1, 0));
        bus.color = 2'd0;
        step("full_idle", snap(0, 9'b100_010_001, 0, 2'd0, 1, 0));
        tick();
        bus.color = 2'd2;
        tick_n(3);
        step("latch4_wrap", snap(1, 9'b000_000_010, 0, 2'd1, 0, 0));
        tick_n(2);
        bus.color = 2'd0;
        tick_n(2);

        // Clear from IDLE
        bus.clear = 1'b1;
        step("clear_idle", snap(0, 9'h000, 0, 2'd0, 0, 0));
        bus.clear = 1'b0;

        // Stability filter
        for (int i = 0; i < 20; i++) begin
            bus.color = (i % 2 == 1) ? 2'd2 : 2'd1;
            tick();
        end
        bus.color = 2'd3;
        tick_n(2);
        step("filter_unstable", snap(0, 9'h000, 0, 2'd0, 0, 0));
        bus.color = 2'd0;
        tick();

        // Clear priority over a coincident latch event
        bus.color = 2'd3;
        tick_n(5);
        step("latch_before_clr", snap(1, 9'b000_000_100, 0, 2'd1, 0, 0));
        bus.color = 2'd0;
        tick_n(2);
        bus.color = 2'd1;
        tick_n(3);
        bus.clear = 1'b1;
        step("clear_priority", snap(0, 9'h000, 0, 2'd0, 0, 0));
        bus.clear = 1'b0;
        bus.color = 2'd0;
        tick();

        // Blink: enter from HOLD
        bus.color = 2'd2;
        tick_n(3);
        step("latch_before_blink", snap(1, 9'b000_000_010, 0, 2'd1, 0, 0));
        bus.done  = 1'b1;
        bus.color = 2'd0;
        for (int k = 1; k <= 25; k++) begin
            step("blink", snap(0, ((((k - 1) / BLINK_CYC) % 2) == 1) ? {3{BLINK_COLOR}} : 9'h000,
                               0, 2'd1, 0, 1));
        end
        bus.done = 1'b0;
        step("blink_exit", snap(0, 9'h000, 0, 2'd0, 0, 0));

        // MI retrigger: pulses at cycle 0 and 6 -> yellow from cycle 1 to 16
        for (int c = 0; c <= 20; c++) begin
            bus.mi_led = (c == 0 || c == 6);
            step("mi_retrig", snap(0, 9'h000, (c + 1 <= 16), 2'd0, 0, 0));
        end
        // MI held high: exactly MI_CYC yellow cycles
        bus.mi_led = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step("mi_level", snap(0, 9'h000, (c < MI_CYC), 2'd0, 0, 0));
        end
        bus.mi_led = 1'b0;
        tick();

        // Reset during blink on-phase with MI running
        bus.done   = 1'b1;
        bus.mi_led = 1'b1;
        step("rst_blink_entry", snap(0, 9'h000, 1, 2'd0, 0, 1));
        bus.mi_led = 1'b0;
        tick_n(5);
        step("rst_blink_on", snap(0, {3{BLINK_COLOR}}, 1, 2'd0, 0, 1));
        rst_n = 1'b0;
        step("rst_mid", snap(0, 9'h000, 0, 2'd0, 0, 0));
        rst_n     = 1'b1;
        bus.done  = 1'b0;
        bus.color = 2'd1;
        tick_n(3);
        step("post_rst_latch", snap(1, 9'b000_000_001, 0, 2'd1, 0, 0));
        bus.color = 2'd0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/patch_led_sequencer.md
# patch_led_sequencer

Parametrised successor to the three-LED patch indicator. It latches each detected patch color into the next of `NUM_LEDS` RGB slots, with a stability filter on `color`. It wraps when all slots are full and blinks every slot while `done` is high. It also drives a retriggerable yellow MI indicator. The block sits between the color detector / CSL decoder and the board RGB LED pins.

## Interface
Parameters:
- `NUM_LEDS`, 3: number of RGB slots (1..8).
- `STABLE_CYC`, 4: consecutive identical nonzero `color` samples required before latching (≥1).
- `BLINK_CYC`, 1000000: cycles per blink half-period (≥1).
- `MI_CYC`, 2000000: cycles the MI LED stays yellow per trigger (≥1).
- `BLINK_COLOR`, 3'b010: color shown on all slots during the blink on-phase.

Ports:
- `clk_1MHz`  in  1  system clock. One clock domain only.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `color`  in  2  detected color: 0 none, 1 red, 2 green, 3 blue.
- `done`  in  1  level; high selects blink mode.
- `mi_led`  in  1  MI trigger from the CSL decoder; rising-edge sensitive.
- `clear`  in  1  single-cycle request to empty all slots.
- `patch_enable`  out  1  high while a latched patch is still present.
- `rgb_leds`  out  3*NUM_LEDS  slot k is at bits [3k+2:3k]; bit0 R, bit1 G, bit2 B.
- `rgb_mi`  out  3  3'b011 (yellow) while the MI timer runs, else 0.
- `led_idx`  out  max(1,clog2(NUM_LEDS))  next slot to be written.
- `full`  out  1  all slots written since the last wrap or clear.
- `blinking`  out  1  high in BLINK state.

## Operation
- **Reset** (`rst_n`=0 at an edge): every output is 0. State is IDLE. All counters, `led_idx`, `full` and the `mi_led` edge register are cleared. Reset wins over every other input, including mid-blink and mid-MI.
- **Color map**: 1→3'b001, 2→3'b010, 3→3'b100.
- **Stability filter**: a latch event occurs on the edge where `color` has been sampled nonzero and equal on `STABLE_CYC` consecutive edges. Any change or a 0 restarts the count.
- **States**: IDLE, HOLD, BLINK.
- **IDLE**
  - On a latch event:
    - If `full`=1, clear all slots in the same cycle before writing.
    - Write the mapped color to slot `led_idx`.
    - Set `patch_enable`=1 and go to HOLD.
    - `led_idx` increments, wrapping NUM_LEDS-1→0.
    - `full` is set to 1 if `led_idx` was NUM_LEDS-1 before the write, else 0.
- **HOLD**
  - `patch_enable` stays 1 and no further latching occurs.
  - When `color`=0 is sampled: `patch_enable` goes to 0 and the state goes to IDLE. The filter count is 0 at that point.
- **`clear`** in IDLE or HOLD: zero all slots, `led_idx`=0, `full`=0, `patch_enable`=0, state IDLE. `clear` takes priority over a latch event in the same cycle. It is ignored in BLINK.
- **BLINK**
  - Entry: `done`=1 from any state, with priority over `clear` and latch.
  - On entry: phase=off, blink counter=0, `patch_enable`=0, `blinking`=1.
  - The counter counts 0..BLINK_CYC-1, then toggles phase and restarts.
  - `rgb_leds` = BLINK_COLOR replicated on every slot when phase=on, else 0.
  - Exit on `done`=0: all slots are zeroed, `led_idx`=0, `full`=0, state IDLE, `blinking`=0.
- **MI timer**
  - Independent of the main state machine and active in every state.
  - A rising edge of `mi_led` (current 1, previous sample 0) loads `mi_cnt`=MI_CYC. A rising edge while the timer is running reloads it.
  - Otherwise `mi_cnt` decrements when nonzero.
  - `rgb_mi` = 3'b011 iff `mi_cnt`≠0. A level held high does not retrigger.
- **Widths**:
  - The blink counter is clog2(BLINK_CYC) bits.
  - `mi_cnt` is clog2(MI_CYC+1) bits.
  - No counter may overflow at the maximum parameter values.

## Timing
- All outputs are registered, or decoded directly from registers. Every change is visible in the cycle after the causing edge.
- Latch latency: `color`=c first sampled at edge t (stable) → slot written and `patch_enable`=1 after edge t+STABLE_CYC-1.
- `patch_enable` falls one cycle after the first `color`=0 sample in HOLD.
- Blink: LEDs are off for BLINK_CYC cycles after entry, then on for BLINK_CYC, and so on. The period is 2·BLINK_CYC.
- MI: `mi_led` rising-edge sample at edge t → `rgb_mi` yellow for exactly MI_CYC cycles, starting after edge t.
- Simultaneous `done` rising with a latch event: BLINK is taken and the latch is discarded.

## Test plan
- **Sequential latch and wrap.** Settings: NUM_LEDS=3, STABLE_CYC=4. Stimulus: present color 1, 2, 3, each held 6 cycles with 2 zero cycles between; then present color 2. Required response:
  - Slots go to 001, 010, 100 and `full`=1.
  - The fourth patch gives slot0=010, slots1-2=0, `led_idx`=1, `full`=0.
- **Stability filter.** Stimulus: color toggles 1,2,1,2 every cycle for 20 cycles, then holds 3 for 3 cycles. Required response: no latch, `rgb_leds`=0, `patch_enable`=0.
- **Blink.** Settings: BLINK_CYC=5. Stimulus: `done`=1 for 25 cycles. Required response: `rgb_leds` is 0 for 5 cycles, then BLINK_COLOR on all slots for 5 cycles, repeating. `done`=0 then gives all 0 and `led_idx`=0.
- **MI retrigger.** Settings: MI_CYC=10. Stimulus: `mi_led` pulse at cycle 0 and again at cycle 6. Required response: `rgb_mi`=011 from cycle 1 through cycle 16, then 0. `mi_led` held high yields exactly 10 cycles.
- **Clear priority.** Stimulus: `clear` asserted on the same edge as a latch event. Required response: slots 0, `led_idx`=0, `patch_enable`=0.
- **Reset mid-operation.** Stimulus: `rst_n`=0 for one edge during BLINK on-phase with the MI timer active. Required response: all outputs 0 the next cycle; normal latching resumes afterwards.
